// File: rtl/sccb_write_master.sv
// SCCB 3-phase write engine: takes one {id, addr, data} triple per handshake and
// serialises it on sio_c_o / sio_d_io with START, 27 bit slots, STOP and a bus-free gap.
module sccb_write_master #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCCB_FREQ_HZ = 100_000,
    parameter int QTR_DIV      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ)
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_id_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       sio_c_o,
    inout  wire        sio_d_io
);
    localparam int            QW    = $clog2(QTR_DIV);
    localparam logic [QW-1:0] QLAST = QW'(QTR_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP} state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [3:0]    bit_cnt;
    logic [1:0]    phase;
    logic [23:0]   shreg;
    logic          sda;
    logic          sda_oe;
    logic          qtick;

    assign sio_d_io = sda_oe ? sda : 1'bz;
    assign qtick    = (qcnt == QLAST);

    // Every bus change happens on a quarter tick and sets the levels of the quarter being entered.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state       <= IDLE;
            qcnt        <= '0;
            quarter     <= '0;
            bit_cnt     <= '0;
            phase       <= '0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            ack_err_o   <= 1'b0;
            sio_c_o     <= 1'b1;
            sda         <= 1'b1;
            sda_oe      <= 1'b1;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (req_valid_i) begin
                    shreg       <= {req_id_i, req_addr_i, req_data_i};
                    state       <= START;
                    qcnt        <= '0;
                    quarter     <= '0;
                    req_ready_o <= 1'b0;
                    busy_o      <= 1'b1;
                    ack_err_o   <= 1'b0;
                    sio_c_o     <= 1'b1;
                    sda_oe      <= 1'b1;
                    sda         <= 1'b1;
                end
            end else if (!qtick) begin
                qcnt <= qcnt + 1'b1;
            end else begin
                qcnt    <= '0;
                quarter <= quarter + 2'd1;
                case (state)
                    START: begin
                        case (quarter)
                            2'd0: sda <= 1'b0;
                            2'd1: sio_c_o <= 1'b0;
                            2'd3: begin
                                state   <= BIT;
                                bit_cnt <= '0;
                                phase   <= '0;
                                sda     <= shreg[23];
                            end
                            default: ;
                        endcase
                    end
                    BIT: begin
                        case (quarter)
                            2'd0: sio_c_o <= 1'b1;
                            // 9th bit: the tick closing Q1 is the sample point for the don't-care bit
                            2'd1: if (bit_cnt == 4'd8 && sio_d_io == 1'b1) ack_err_o <= 1'b1;
                            2'd2: sio_c_o <= 1'b0;
                            2'd3: begin
                                if (bit_cnt == 4'd8) begin
                                    bit_cnt <= '0;
                                    sda_oe  <= 1'b1;
                                    if (phase == 2'd2) begin
                                        state <= STOP;
                                        sda   <= 1'b0;
                                    end else begin
                                        phase <= phase + 2'd1;
                                        sda   <= shreg[23];
                                    end
                                end else begin
                                    shreg   <= {shreg[22:0], 1'b0};
                                    bit_cnt <= bit_cnt + 4'd1;
                                    if (bit_cnt == 4'd7) sda_oe <= 1'b0;
                                    else                 sda    <= shreg[22];
                                end
                            end
                        endcase
                    end
                    STOP: begin
                        case (quarter)
                            2'd0: sio_c_o <= 1'b1;
                            2'd1: sda <= 1'b1;
                            2'd3: state <= GAP;
                            default: ;
                        endcase
                    end
                    GAP: begin
                        if (quarter == 2'd3) begin
                            state       <= IDLE;
                            done_o      <= 1'b1;
                            req_ready_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master: table of write triples plus hand sequences, with a bus
// decoder / ack-slave model feeding a scoreboard that checks each completed write.
module tb_sccb_write_master;
    localparam int QTR = 2;
    localparam int TXN = 120 * QTR;

    typedef struct {
        logic [7:0] id;
        logic [7:0] addr;
        logic [7:0] data;
        logic [2:0] mask;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] id;
        logic [7:0] addr;
        logic [7:0] data;
        logic [2:0] mask;
        logic       err;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_id = '0, req_addr = '0, req_data = '0;
    logic       req_ready, busy, done, ack_err, sio_c;
    wire        sio_d;
    logic       slave_low = 1'b0;

    assign sio_d = slave_low ? 1'b0 : 1'bz;
    pullup (sio_d);

    always #5 clk = ~clk;

    sccb_write_master #(.CLK_FREQ_HZ(800_000), .SCCB_FREQ_HZ(100_000), .QTR_DIV(QTR)) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_id_i   (req_id),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .busy_o     (busy),
        .done_o     (done),
        .ack_err_o  (ack_err),
        .sio_c_o    (sio_c),
        .sio_d_io   (sio_d)
    );

    int         checks = 0, errors = 0;
    int         cyc = 0;
    logic [2:0] cur_mask = '0;
    logic       cur_err = 1'b0;
    logic       hs_pending = 1'b0;
    int         last_acc = 0, last_done = 0, n_done = 0;
    exp_t       q[$];

    // bus decoder state
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         rbits = 0, starts = 0, stops = 0, viol = 0, busy_cnt = 0, wcnt = 0;
    int         ph, pos;
    logic [7:0] bytes [3];
    logic [2:0] acks;
    exp_t       e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Decoder, open-drain slave and scoreboard, all sampled on the falling clock edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rbits = 0; starts = 0; stops = 0; viol = 0; busy_cnt = 0; wcnt = 0;
            slave_low = 1'b0; hs_pending = 1'b0;
            q.delete();
        end else begin
            if (done) begin
                n_done++;
                last_done = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("byte_id", {24'd0, bytes[0]}, {24'd0, e.id});
                    chk("byte_addr", {24'd0, bytes[1]}, {24'd0, e.addr});
                    chk("byte_data", {24'd0, bytes[2]}, {24'd0, e.data});
                    chk("ninth_bits", {29'd0, acks}, {29'd0, e.mask});
                    chk("ack_err_at_done", {31'd0, ack_err}, {31'd0, e.err});
                    chk("done_latency", cyc - e.acc, TXN);
                    chk("busy_cycles", busy_cnt, TXN);
                    chk("start_edges", starts, 1);
                    chk("stop_edges", stops, 1);
                    chk("sda_while_scl_high", viol, 0);
                end
                rbits = 0; starts = 0; stops = 0; viol = 0; busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (prev_scl && sio_c && (sio_d !== prev_sda)) begin
                if (prev_sda === 1'b1 && sio_d === 1'b0) begin
                    starts++;
                    rbits = 0;
                end else if (prev_sda === 1'b0 && sio_d === 1'b1) stops++;
                else viol++;
            end
            if (!prev_scl && sio_c) begin
                if (rbits < 27) begin
                    ph = rbits / 9;
                    pos = rbits % 9;
                    if (pos < 8) bytes[ph] = {bytes[ph][6:0], sio_d};
                    else acks[ph] = sio_d;
                end else if (rbits > 27) viol++;
                rbits++;
            end
            // slave pulls SDA low for the 9th bit a quarter after the 8th SCL falls
            if (prev_scl && !sio_c) begin
                if (rbits >= 1 && rbits <= 27) begin
                    pos = (rbits - 1) % 9;
                    if (pos == 7) wcnt = QTR;
                    else if (pos == 8) slave_low = 1'b0;
                end
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) slave_low = (q.size() > 0) ? !q[0].mask[(rbits - 1) / 9] : 1'b0;
            end
            hs_pending = req_valid && req_ready;
            if (hs_pending) begin
                q.push_back('{req_id, req_addr, req_data, cur_mask, cur_err, cyc + 1});
                last_acc = cyc + 1;
            end
        end
        prev_scl = sio_c;
        prev_sda = sio_d;
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (hs_pending) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < TXN + 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] id, addr, data, input logic [2:0] mask, input logic err);
        @(posedge clk);
        #1;
        req_id = id; req_addr = addr; req_data = data;
        cur_mask = mask; cur_err = err;
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs [6];
    int   nd;

    initial begin
        vecs[0] = '{8'h42, 8'h12, 8'h80, 3'b000, 1'b0};
        vecs[1] = '{8'h42, 8'h12, 8'h80, 3'b010, 1'b1};
        vecs[2] = '{8'h42, 8'hFF, 8'h00, 3'b000, 1'b0};
        vecs[3] = '{8'h60, 8'hA5, 8'h5A, 3'b100, 1'b1};
        vecs[4] = '{8'h20, 8'h01, 8'hFE, 3'b001, 1'b1};
        vecs[5] = '{8'h42, 8'h3C, 8'hC3, 3'b111, 1'b1};

        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_scl", {31'd0, sio_c}, 32'd1);
        chk("rst_sda", {31'd0, sio_d}, 32'd1);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].id, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].err);
            wait_done();
        end

        // sticky ack_err: holds after done, cleared by the next acceptance
        send(8'h42, 8'h12, 8'h80, 3'b010, 1'b1);
        wait_done();
        repeat (20) @(negedge clk);
        chk("ack_err_sticky", {31'd0, ack_err}, 32'd1);
        send(8'h42, 8'h12, 8'h80, 3'b000, 1'b0);
        @(negedge clk);
        chk("ack_err_cleared", {31'd0, ack_err}, 32'd0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done();

        // back-to-back: second triple queued behind the first with valid held high
        @(posedge clk);
        #1;
        req_id = 8'h42; req_addr = 8'h11; req_data = 8'h01;
        cur_mask = 3'b000; cur_err = 1'b0;
        req_valid = 1'b1;
        wait_accept();
        req_addr = 8'h3A; req_data = 8'h04;
        wait_accept();
        req_valid = 1'b0;
        chk("b2b_accept_in_done_cycle", last_acc, last_done + 1);
        @(negedge clk);
        chk("b2b_start_q0_scl", {31'd0, sio_c}, 32'd1);
        chk("b2b_start_q0_sda", {31'd0, sio_d}, 32'd1);
        repeat (QTR) @(negedge clk);
        chk("b2b_start_q1_scl", {31'd0, sio_c}, 32'd1);
        chk("b2b_start_q1_sda", {31'd0, sio_d}, 32'd0);
        wait_done();

        // request while busy is ignored; the bus keeps the original bytes
        send(8'h42, 8'h12, 8'h80, 3'b000, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        req_id = 8'h99; req_addr = 8'h77; req_data = 8'h55; req_valid = 1'b1;
        @(negedge clk);
        chk("ready_low_while_busy", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done();

        // reset during phase 2, bit 4
        send(8'h42, 8'hC3, 8'h3C, 3'b000, 1'b0);
        for (int i = 0; i < 2000 && rbits < 13; i++) @(posedge clk);
        chk("reached_phase2_bit4", (rbits >= 13) ? 32'd1 : 32'd0, 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_scl", {31'd0, sio_c}, 32'd1);
        chk("midrst_sda", {31'd0, sio_d}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        nd = n_done;
        repeat (TXN) @(negedge clk);
        chk("no_done_after_reset", n_done - nd, 0);
        send(8'h42, 8'h12, 8'h80, 3'b000, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
